// File: rtl/reg_bank_encapsulation_pkg.sv
// Shared types, indices and reset values for the register bank.
// Optional LDM/STM Rd selection is built with macro REG_BANK_LSM_EN.
package reg_bank_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  reg_idx_t;

    localparam int       NUM_REGS = 16;
    localparam reg_idx_t REG_ST   = 4'd12;
    localparam reg_idx_t REG_SP   = 4'd13;
    localparam reg_idx_t REG_LR   = 4'd14;
    localparam reg_idx_t REG_PC   = 4'd15;
    localparam word_t    PC_INC   = 32'd4;
    localparam word_t    ST_RST   = 32'd4;
    localparam word_t    SP_RST   = 32'h0000_3000;

    // R0..R11 reset to index+1; R12 is status; R13..R15 share one value.
    function automatic word_t rst_val(input int i);
        if (i < int'(REG_ST)) return word_t'(i + 1);
        if (i == int'(REG_ST)) return ST_RST;
        return SP_RST;
    endfunction

endpackage

// File: rtl/reg_bank_encapsulation_if.sv
// Control, instruction and always-driven data signals of the register bank.
// Built identically with or without REG_BANK_LSM_EN.
interface reg_bank_encapsulation_if;
    import reg_bank_pkg::*;

    logic  LATCH_REG;
    logic  PC_MUX;
    logic  IR_RD_MUX;
    logic  LSM_RD_MUX;
    logic  RD_MUX;
    logic  DATA_MUX;
    logic  REG_GATE_B;
    logic  REG_GATE_C;
    word_t IR;
    word_t ALU_BUS;
    word_t A_BUS;
    word_t ST;
    word_t PC;

    modport master (
        output LATCH_REG, PC_MUX, IR_RD_MUX, LSM_RD_MUX,
        output RD_MUX, DATA_MUX, REG_GATE_B, REG_GATE_C,
        output IR, ALU_BUS,
        input  A_BUS, ST, PC
    );

    modport slave (
        input  LATCH_REG, PC_MUX, IR_RD_MUX, LSM_RD_MUX,
        input  RD_MUX, DATA_MUX, REG_GATE_B, REG_GATE_C,
        input  IR, ALU_BUS,
        output A_BUS, ST, PC
    );

endinterface

// File: rtl/reg_bank_encapsulation_core.sv
// 16x32 storage: three combinational read ports, one write port, PC bump.
// Independent of REG_BANK_LSM_EN.
module reg_bank_core
    import reg_bank_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  reg_idx_t ra,
    input  reg_idx_t rb,
    input  reg_idx_t rc,
    input  logic     we,
    input  reg_idx_t wa,
    input  word_t    wd,
    input  logic     pc_we,
    input  word_t    pc_wd,
    output word_t    rd_a,
    output word_t    rd_b,
    output word_t    rd_c,
    output word_t    st,
    output word_t    pc
);

    word_t regs_q [NUM_REGS];
    word_t regs_d [NUM_REGS];

    // Port write comes last so it overrides the PC increment when wa is R15.
    always_comb begin
        regs_d = regs_q;
        if (pc_we) regs_d[REG_PC] = pc_wd;
        if (we)    regs_d[wa]     = wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= rst_val(i);
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_a = regs_q[ra];
    assign rd_b = regs_q[rb];
    assign rd_c = regs_q[rc];
    assign st   = regs_q[REG_ST];
    assign pc   = regs_q[REG_PC];

endmodule

// File: rtl/reg_bank_encapsulation.sv
// Register bank top: IR field decode, write-data mux and B/C bus gating.
// Define REG_BANK_LSM_EN to take Rd from the LDM/STM register list.
module reg_bank_encapsulation
    import reg_bank_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    reg_bank_encapsulation_if.slave bus,
    output wire  [31:0]             B_BUS,
    output wire  [31:0]             C_BUS
);

`ifdef REG_BANK_LSM_EN
    function automatic reg_idx_t lowest_set(input logic [15:0] v);
        reg_idx_t r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) r = reg_idx_t'(i);
        end
        return r;
    endfunction
`endif

    reg_idx_t rn, rd, rs, rm;
    word_t    rd_a, rd_b, rd_c;
    word_t    st_w, pc_w, pc_plus, data_in;

    always_comb begin
        rs = bus.IR[11:8];
        rm = bus.IR[3:0];
        if (bus.IR_RD_MUX) begin
            rn = bus.IR[19:16];
            rd = bus.IR[15:12];
        end else begin
            rn = bus.IR[15:12];
            rd = bus.IR[19:16];
        end
        if (bus.RD_MUX) rd = REG_PC;
`ifdef REG_BANK_LSM_EN
        else if (bus.LSM_RD_MUX) rd = lowest_set(bus.IR[15:0]);
`endif
    end

`ifndef REG_BANK_LSM_EN
    logic unused_lsm;
    assign unused_lsm = bus.LSM_RD_MUX;
`endif

    logic unused_ir;
    assign unused_ir = ^{bus.IR[31:20], bus.IR[7:4]};

    assign pc_plus = pc_w + PC_INC;
    assign data_in = bus.DATA_MUX ? bus.ALU_BUS : pc_plus;

    reg_bank_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .ra    (rn),
        .rb    (rm),
        .rc    (rs),
        .we    (bus.LATCH_REG),
        .wa    (rd),
        .wd    (data_in),
        .pc_we (bus.LATCH_REG & bus.PC_MUX),
        .pc_wd (pc_plus),
        .rd_a  (rd_a),
        .rd_b  (rd_b),
        .rd_c  (rd_c),
        .st    (st_w),
        .pc    (pc_w)
    );

    assign bus.A_BUS = rd_a;
    assign bus.ST    = st_w;
    assign bus.PC    = pc_w;
    assign B_BUS     = bus.REG_GATE_B ? rd_b : 32'hzzzz_zzzz;
    assign C_BUS     = bus.REG_GATE_C ? rd_c : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_reg_bank_encapsulation.sv
// Directed bench for reg_bank_encapsulation; LSM case follows REG_BANK_LSM_EN.
module tb_reg_bank_encapsulation;

    logic        clk;
    logic        rst_n;
    wire  [31:0] b_bus;
    wire  [31:0] c_bus;
    int          total;
    int          bad;
    logic [31:0] exp_r [16];

    reg_bank_encapsulation_if bus ();

    reg_bank_encapsulation dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .B_BUS (b_bus),
        .C_BUS (c_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // An undriven bus reads Z in a 4-state simulator and 0 in a 2-state one.
    task automatic chk_z(input string tag, input logic [31:0] obs);
        total++;
        assert (obs === 32'hzzzz_zzzz || obs === 32'h0) else begin
            bad++;
            $error("FAIL %s observed=%h expected=Z", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_reg(input int i, input logic [31:0] exp);
        bus.LATCH_REG = 1'b0;
        bus.PC_MUX    = 1'b0;
        bus.RD_MUX    = 1'b0;
        bus.IR_RD_MUX = 1'b1;
        bus.IR        = 32'(i) << 16;
        #1;
        chk($sformatf("R%0d", i), bus.A_BUS, exp);
    endtask

    task automatic idle();
        bus.LATCH_REG  = 1'b0;
        bus.PC_MUX     = 1'b0;
        bus.IR_RD_MUX  = 1'b0;
        bus.LSM_RD_MUX = 1'b0;
        bus.RD_MUX     = 1'b0;
        bus.DATA_MUX   = 1'b0;
        bus.REG_GATE_B = 1'b0;
        bus.REG_GATE_C = 1'b0;
        bus.IR         = 32'h0;
        bus.ALU_BUS    = 32'h0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 12; i++) exp_r[i] = 32'(i + 1);
        exp_r[12] = 32'd4;
        exp_r[13] = 32'h3000;
        exp_r[14] = 32'h3000;
        exp_r[15] = 32'h3000;

        rst_n = 1'b1;
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_a_bus", bus.A_BUS, 32'd1);
        chk_z("rst_b_bus", b_bus);
        chk_z("rst_c_bus", c_bus);
        chk("rst_st", bus.ST, 32'd4);
        chk("rst_pc", bus.PC, 32'h3000);
        for (int i = 0; i < 16; i++) rd_reg(i, exp_r[i]);
        @(negedge clk);
        rst_n = 1'b1;

        // R15 <- R15+4 through the Rd port, read back on B then A
        @(negedge clk);
        idle();
        bus.IR         = 32'h0000_000F;
        bus.RD_MUX     = 1'b1;
        bus.LATCH_REG  = 1'b1;
        bus.REG_GATE_B = 1'b1;
        #1;
        chk("pc_b_before", b_bus, 32'h3000);
        tick();
        chk("pc_inc1", bus.PC, 32'h3004);
        chk("pc_inc1_b", b_bus, 32'h3004);
        bus.IR        = 32'h000F_0000;
        bus.IR_RD_MUX = 1'b1;
        tick();
        chk("pc_inc2", bus.PC, 32'h3008);
        chk("pc_inc2_a", bus.A_BUS, 32'h3008);
        exp_r[15] = 32'h3008;

        // no latch: PC holds, C reads R15
        @(negedge clk);
        idle();
        bus.IR         = 32'h0000_0F00;
        bus.IR_RD_MUX  = 1'b1;
        bus.REG_GATE_C = 1'b1;
        #1;
        chk("hold_c", c_bus, 32'h3008);
        chk("hold_a", bus.A_BUS, 32'd1);
        chk_z("hold_b_z", b_bus);
        tick();
        chk("hold_pc", bus.PC, 32'h3008);

        // data-processing format write R5 <- ALU
        @(negedge clk);
        idle();
        bus.IR         = 32'h0008_5001;
        bus.IR_RD_MUX  = 1'b1;
        bus.REG_GATE_B = 1'b1;
        bus.DATA_MUX   = 1'b1;
        bus.ALU_BUS    = 32'd11;
        bus.LATCH_REG  = 1'b1;
        #1;
        chk("dp_a", bus.A_BUS, 32'd9);
        chk("dp_b", b_bus, 32'd2);
        tick();
        rd_reg(5, 32'd11);
        exp_r[5] = 32'd11;

        // multiply format: fields swapped, Rd = R14
        @(negedge clk);
        idle();
        bus.IR         = 32'h000E_2007;
        bus.REG_GATE_B = 1'b1;
        bus.DATA_MUX   = 1'b1;
        bus.ALU_BUS    = 32'd24;
        #1;
        chk("mul_a", bus.A_BUS, 32'd3);
        chk("mul_b", b_bus, 32'd8);
        tick();
        rd_reg(14, 32'h3000);
        @(negedge clk);
        bus.IR        = 32'h000E_2007;
        bus.IR_RD_MUX = 1'b0;
        bus.LATCH_REG = 1'b1;
        tick();
        rd_reg(14, 32'd24);
        exp_r[14] = 32'd24;

        // PC_MUX alongside a write to R3
        @(negedge clk);
        idle();
        bus.IR        = 32'h0000_3000;
        bus.IR_RD_MUX = 1'b1;
        bus.DATA_MUX  = 1'b1;
        bus.ALU_BUS   = 32'h55;
        bus.LATCH_REG = 1'b1;
        bus.PC_MUX    = 1'b1;
        tick();
        chk("pcmux_pc", bus.PC, 32'h300C);
        rd_reg(3, 32'h55);
        exp_r[3] = 32'h55;

        // PC_MUX with Rd = 15: the Rd write wins
        @(negedge clk);
        idle();
        bus.RD_MUX    = 1'b1;
        bus.DATA_MUX  = 1'b1;
        bus.ALU_BUS   = 32'h100;
        bus.LATCH_REG = 1'b1;
        bus.PC_MUX    = 1'b1;
        tick();
        chk("rd_wins", bus.PC, 32'h100);

        // R15+4 wraps to zero
        @(negedge clk);
        idle();
        bus.RD_MUX    = 1'b1;
        bus.DATA_MUX  = 1'b1;
        bus.ALU_BUS   = 32'hFFFF_FFFC;
        bus.LATCH_REG = 1'b1;
        tick();
        chk("wrap_pre", bus.PC, 32'hFFFF_FFFC);
        bus.DATA_MUX = 1'b0;
        tick();
        chk("wrap", bus.PC, 32'h0);
        exp_r[15] = 32'h0;

        // ST tracks R12; old value visible until the edge
        @(negedge clk);
        idle();
        bus.IR        = 32'h0000_C000;
        bus.IR_RD_MUX = 1'b1;
        bus.DATA_MUX  = 1'b1;
        bus.ALU_BUS   = 32'hA5;
        bus.LATCH_REG = 1'b1;
        #1;
        chk("st_old", bus.ST, 32'd4);
        tick();
        chk("st_new", bus.ST, 32'hA5);
        exp_r[12] = 32'hA5;

        // LDM/STM list 0x0050: lowest set bit is 4
        @(negedge clk);
        idle();
        bus.IR         = 32'h0000_0050;
        bus.IR_RD_MUX  = 1'b1;
        bus.LSM_RD_MUX = 1'b1;
        bus.DATA_MUX   = 1'b1;
        bus.ALU_BUS    = 32'hDEAD_BEEF;
        bus.LATCH_REG  = 1'b1;
        tick();
        bus.LSM_RD_MUX = 1'b0;
`ifdef REG_BANK_LSM_EN
        exp_r[4] = 32'hDEAD_BEEF;
`else
        exp_r[0] = 32'hDEAD_BEEF;
`endif
        for (int i = 0; i < 16; i++) rd_reg(i, exp_r[i]);

        // empty list selects R0
        @(negedge clk);
        idle();
        bus.IR         = 32'h0005_0000;
        bus.IR_RD_MUX  = 1'b1;
        bus.LSM_RD_MUX = 1'b1;
        bus.DATA_MUX   = 1'b1;
        bus.ALU_BUS    = 32'h1234;
        bus.LATCH_REG  = 1'b1;
        tick();
        rd_reg(0, 32'h1234);
        rd_reg(5, 32'd11);

        // async reset mid-cycle beats a pending write
        @(negedge clk);
        idle();
        bus.IR        = 32'h0000_1000;
        bus.IR_RD_MUX = 1'b1;
        bus.DATA_MUX  = 1'b1;
        bus.ALU_BUS   = 32'h77;
        bus.LATCH_REG = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc", bus.PC, 32'h3000);
        chk("arst_st", bus.ST, 32'd4);
        chk("arst_r0", bus.A_BUS, 32'd1);
        tick();
        rd_reg(1, 32'd2);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.IR        = 32'h0000_1000;
        bus.IR_RD_MUX = 1'b1;
        bus.LATCH_REG = 1'b1;
        tick();
        rd_reg(1, 32'h77);
        rd_reg(5, 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
